// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - cache line to burst memory bus adaptor
//
// Converts whole-line cache requests into BEATS = LINE_WIDTH/BURST_WIDTH
// memory beats. Beats are always in ascending order, so beat 0 is line bits
// [BURST_WIDTH-1:0]. The memory may leave gaps between beats.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   address_i          line request byte address from the cache
//   read_i, write_i    line read / write request (read wins when both are high)
//   line_i             line write data
//   line_o             assembled read line, held until the next read beat
//   resp_o             one-cycle transaction complete pulse
//   address_o          line-aligned burst address to memory
//   read_o, write_o    burst read / write request
//   burst_o            write beat data, valid for the whole WRITE state
//   burst_i            read beat data
//   resp_i             memory beat handshake, one beat per high cycle
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  generate
    if ((BEATS < 2) || ((BEATS & (BEATS - 1)) != 0) ||
        (BEATS * BURST_WIDTH != LINE_WIDTH)) begin : g_param_check
      $error("cacheline_burst_adaptor: LINE_WIDTH/BURST_WIDTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  // Write data lives in its own buffer so a write never disturbs line_o.
  logic [LINE_WIDTH-1:0] wr_buf;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  assign aligned_addr = {address_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

  // Decoded from registers only; zero outside WRITE so reset/idle drive 0.
  assign burst_o = (state == WRITE) ? wr_buf[cnt*BURST_WIDTH +: BURST_WIDTH]
                                    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_buf    <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (read_i) begin
            address_o <= aligned_addr;
            read_o    <= 1'b1;
            state     <= READ;
          end else if (write_i) begin
            address_o <= aligned_addr;
            wr_buf    <= line_i;
            write_o   <= 1'b1;
            state     <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            // Stop at the last beat instead of letting cnt wrap.
            if (cnt == LAST) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (cnt == LAST) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
